// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared constants, size codes and FSM encoding for the load/store unit.
package ysyx_22051013_lsu_pkg;

   localparam int LSU_XLEN   = 64;
   localparam int LSU_STRB_W = LSU_XLEN / 8;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Natural alignment: an access of 2^size bytes must start on a 2^size boundary.
   function automatic logic misaligned(input mem_size_e size, input logic [2:0] off);
      logic mis;
      case (size)
         MEM_B:   mis = 1'b0;
         MEM_H:   mis = off[0];
         MEM_W:   mis = |off[1:0];
         default: mis = |off;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_if.sv
// Data-memory valid/ready bus between the LSU (master) and memory (slave).
interface ysyx_22051013_lsu_if;
   import ysyx_22051013_lsu_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wen;
   logic [LSU_XLEN-1:0]   req_addr;
   logic [LSU_XLEN-1:0]   req_wdata;
   logic [LSU_STRB_W-1:0] req_wstrb;
   logic                  resp_valid;
   logic [LSU_XLEN-1:0]   resp_rdata;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

// File: rtl/ysyx_22051013_lsu_align.sv
// Byte-lane alignment: store shift and strobes, load shift and sign/zero extension.
module ysyx_22051013_lsu_align
   import ysyx_22051013_lsu_pkg::*;
(
   input  logic [2:0]            off,
   input  mem_size_e             size,
   input  logic                  zext,
   input  logic [LSU_XLEN-1:0]   store_data,
   input  logic [LSU_XLEN-1:0]   rdata,
   output logic [LSU_XLEN-1:0]   wdata,
   output logic [LSU_STRB_W-1:0] wstrb,
   output logic [LSU_XLEN-1:0]   load_data
);

   function automatic logic [LSU_XLEN-1:0] extend(input logic [LSU_XLEN-1:0] v,
                                                  input mem_size_e sz,
                                                  input logic zx);
      logic signed [LSU_XLEN-1:0] r;
      case (sz)
         MEM_B:   r = zx ? {56'b0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
         MEM_H:   r = zx ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
         MEM_W:   r = zx ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   logic [5:0]                bit_off;
   logic [LSU_STRB_W-1:0]     base_strb;
   logic [LSU_XLEN-1:0]       rdata_sh;

   assign bit_off = {off, 3'b000};

   always_comb begin
      base_strb = 8'h00;
      case (size)
         MEM_B:   base_strb = 8'h01;
         MEM_H:   base_strb = 8'h03;
         MEM_W:   base_strb = 8'h0F;
         default: base_strb = 8'hFF;
      endcase
   end

   assign wdata     = store_data << bit_off;
   assign wstrb     = base_strb << off;
   assign rdata_sh  = rdata >> bit_off;
   assign load_data = extend(rdata_sh, size, zext);

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Load/store stage: one memory transaction per record, single writeback record out.
module ysyx_22051013_lsu
   import ysyx_22051013_lsu_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int STRB_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_mem_ren,
   input  logic                     in_mem_wen,
   input  logic [1:0]               in_mem_size,
   input  logic                     in_mem_unsigned,
   input  logic [XLEN-1:0]          in_exu_res,
   input  logic [XLEN-1:0]          in_store_data,
   input  logic [4:0]               in_rd,
   input  logic                     in_rd_wen,
   ysyx_22051013_lsu_if.master      mem,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_data,
   output logic [4:0]               out_rd,
   output logic                     out_rd_wen,
   output logic                     out_misalign
);

   lsu_state_e          state, state_nxt;
   logic                ren_q, wen_q, zext_q, rd_wen_q, mis_q;
   mem_size_e           size_q;
   logic [XLEN-1:0]     addr_q, sdata_q, data_q;
   logic [4:0]          rd_q;
   logic                in_is_mem, in_mis, accept, req_vld, capture;
   logic [XLEN-1:0]     al_wdata, al_load;
   logic [STRB_W-1:0]   al_wstrb;

   assign in_is_mem = in_mem_ren | in_mem_wen;
   assign in_mis    = in_is_mem & misaligned(mem_size_e'(in_mem_size), in_exu_res[2:0]);
   assign accept    = in_ready & in_valid;
   // A response can coincide with the request handshake on a zero-latency bus.
   assign capture   = mem.resp_valid & ((state == ST_WAIT) | (req_vld & mem.req_ready));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      req_vld   = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (in_is_mem && !in_mis) ? ST_REQ : ST_DONE;
         end
         ST_REQ: begin
            req_vld = 1'b1;
            if (mem.req_ready) state_nxt = mem.resp_valid ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            if (mem.resp_valid) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Record fields need no reset: every output is gated by the FSM state.
   always_ff @(posedge clk) begin
      if (accept) begin
         ren_q    <= in_mem_ren;
         wen_q    <= in_mem_wen;
         size_q   <= mem_size_e'(in_mem_size);
         zext_q   <= in_mem_unsigned;
         addr_q   <= in_exu_res;
         sdata_q  <= in_store_data;
         rd_q     <= in_rd;
         rd_wen_q <= in_rd_wen;
         mis_q    <= in_mis;
         data_q   <= in_is_mem ? '0 : in_exu_res;
      end else if (capture && ren_q) begin
         data_q   <= al_load;
      end
   end

   ysyx_22051013_lsu_align u_align (
      .off        (addr_q[2:0]),
      .size       (size_q),
      .zext       (zext_q),
      .store_data (sdata_q),
      .rdata      (mem.resp_rdata),
      .wdata      (al_wdata),
      .wstrb      (al_wstrb),
      .load_data  (al_load)
   );

   assign mem.req_valid = req_vld;
   assign mem.req_wen   = req_vld & wen_q;
   assign mem.req_addr  = req_vld ? {addr_q[XLEN-1:3], 3'b000} : '0;
   assign mem.req_wdata = (req_vld & wen_q) ? al_wdata : '0;
   assign mem.req_wstrb = (req_vld & wen_q) ? al_wstrb : '0;

   assign out_data     = out_valid ? data_q : '0;
   assign out_rd       = out_valid ? rd_q : 5'd0;
   assign out_rd_wen   = out_valid & rd_wen_q & ~wen_q & ~mis_q;
   assign out_misalign = out_valid & mis_q;

endmodule

// File: doc/ysyx_22051013_lsu.md
Name: ysyx_22051013_lsu

Overview:
Load/store stage directly downstream of the execute stage in the pipelined RV64 core. It takes the execute result, which is either the effective address or the ALU value, together with the store operand and a decoded memory-op descriptor. It performs one data-memory transaction over a valid/ready bus, aligns and extends load data, and hands a single writeback record to the WB stage. Non-memory ops pass through with one cycle of latency.

Parameters:
XLEN, 64, datapath/address width; only 64 is supported.
STRB_W, 8, byte strobes per bus beat (XLEN/8).

Ports:
clk  in  1  core clock.
rst  in  1  asynchronous active-low reset.
in_valid  in  1  execute-stage record valid.
in_ready  out  1  LSU can accept a record.
in_mem_ren  in  1  op is a load.
in_mem_wen  in  1  op is a store (mutually exclusive with ren).
in_mem_size  in  2  0=B, 1=H, 2=W, 3=D.
in_mem_unsigned  in  1  zero-extend the load (LBU/LHU/LWU).
in_exu_res  in  64  effective address for memory ops, otherwise the writeback value.
in_store_data  in  64  store operand, right-justified.
in_rd  in  5  destination register.
in_rd_wen  in  1  register write enable.
mem_req_valid  out  1  bus request valid.
mem_req_ready  in  1  bus accepts request.
mem_req_wen  out  1  1 = write.
mem_req_addr  out  64  address with [2:0] forced to 0.
mem_req_wdata  out  64  lane-shifted store data.
mem_req_wstrb  out  8  byte enables.
mem_resp_valid  in  1  response or write-ack valid (one cycle).
mem_resp_rdata  in  64  aligned 8-byte read data.
out_valid  out  1  writeback record valid.
out_ready  in  1  WB accepts record.
out_data  out  64  writeback value.
out_rd  out  5  destination register.
out_rd_wen  out  1  write enable; forced 0 when misaligned.
out_misalign  out  1  address misaligned for its size; no access performed.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0 except in_ready=1. Any outstanding bus transaction is abandoned. A mem_resp_valid seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid, latch all in_* fields.
  - Misaligned memory op: go to DONE with misalign=1 and no bus activity. Misaligned means H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0.
  - Other memory op: go to REQ.
  - Non-memory op: go to DONE with out_data=in_exu_res.
- REQ: mem_req_valid=1 with all request fields stable until mem_req_ready=1 is sampled, then go to WAIT. If mem_resp_valid arrives in the same cycle as mem_req_ready, go straight to DONE and capture the data.
- WAIT: on mem_resp_valid, capture rdata (loads) and go to DONE. Stores ignore rdata; the response is only an ack. The WAIT state has no timeout.
- DONE: out_valid=1 and the record is held stable. On out_ready, go to IDLE. A new record can be accepted in the following cycle, not the same one.
- Store lane math, with off = addr[2:0]:
  - wdata = store_data << (8*off).
  - wstrb = {B:8'h01, H:8'h03, W:8'h0F, D:8'hFF} << off.
- Load math: sh = rdata >> (8*off); take the low 8/16/32/64 bits, then sign-extend, or zero-extend when unsigned. For D, unsigned has no effect.
- Stores: out_data=0 and out_rd_wen=0 regardless of input.
- Latency with ready always high:
  - Non-mem op: accepted at N, out_valid at N+1.
  - Memory op with a zero-wait bus (ready in REQ, response the next cycle): out_valid at N+3.

Decomposition:
- Shared define header: size codes (MEM_B/H/W/D), FSM state encoding (2-bit), XLEN constant.
- Sub-module ysyx_22051013_lsu_align (combinational): store lane shift and strobe generation, plus load shift and extend. It is reused by a future D-cache.

Test Plan:
- Non-mem op: exu_res=64'h1234, rd=5, wen=1 -> out_valid next cycle, out_data=64'h1234, out_rd=5, no mem_req_valid.
- SB: addr=64'h8000_0003, store_data=64'hAB -> mem_req_addr=64'h8000_0000, wstrb=8'h08, wdata[31:24]=8'hAB; after ack, out_rd_wen=0.
- LH signed: addr=...06, rdata=64'h8001_0000_0000_0000 -> out_data=64'hFFFF_FFFF_FFFF_8001. LHU on the same data -> 64'h8001.
- Misaligned LW at addr=...02 -> out_misalign=1 and out_rd_wen=0 one cycle later; mem_req_valid never asserted.
- Backpressure: hold mem_req_ready=0 for 3 cycles, then out_ready=0 for 2 cycles -> request and output fields stay stable and in_ready stays 0 throughout; exactly one transaction occurs.
- Reset mid-WAIT: drop rst during WAIT -> immediate IDLE, all outputs 0. A late mem_resp_valid is ignored. The next load completes correctly.
